icache_controller: RTL and testbench
====================================

Name: icache_controller

Overview:
- Direct-mapped instruction cache and fill sequencer between the CPU fetch stage and the word-wide instruction memory.
- Hits return the instruction combinationally with no stall.
- On a miss, stalls the CPU via BUSYWAIT and fills one 4-word block from instruction memory with sequential word reads, honouring the memory's BUSYWAIT.
- Sits in the CPU top level, one instance per core.

Parameters:
- ADDR_W, 10: significant byte-address bits; matches the 1024-byte instruction memory.
- NUM_SETS, 8: cache lines; power of two.
- WORDS_PER_BLOCK, 4: 32-bit words per line; power of two.

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  synchronous, active-high reset
- ADDRESS  in  32  CPU fetch byte address (PC)
- READ  in  1  CPU fetch request
- INSTRUCTION  out  32  fetched instruction
- BUSYWAIT  out  1  CPU stall
- MEM_READ  out  1  memory read strobe
- MEM_ADDRESS  out  32  word-aligned memory byte address
- MEM_READDATA  in  32  memory read data
- MEM_BUSYWAIT  in  1  memory not ready; MEM_READDATA valid when low

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high.
- Address split (ADDR_W=10, defaults):
  - [1:0] ignored (byte offset)
  - [3:2] word offset
  - [6:4] index
  - [9:7] tag
  - [31:10] ignored
  - Field widths derive from the parameters via $clog2.
- Storage: per line, a valid bit, tag, and WORDS_PER_BLOCK x 32 data. Storage is flops.
- hit = READ & valid[index] & (tag_array[index] == tag).
- FSM states IDLE, FETCH, UPDATE.
- IDLE:
  - READ=0: BUSYWAIT=0, no action.
  - Hit: INSTRUCTION = data[index][word] combinationally; BUSYWAIT=0 in the same cycle.
  - Miss: BUSYWAIT=1 combinationally. Latch tag/index into fill registers, clear word counter, go to FETCH.
- FETCH:
  - MEM_READ=1; MEM_ADDRESS = {fill_tag, fill_index, cnt, 2'b00}, zero-extended to 32 bits.
  - At each posedge with MEM_BUSYWAIT=0: write MEM_READDATA into data[fill_index][cnt], increment cnt.
  - When the word with cnt==WORDS_PER_BLOCK-1 is accepted, go to UPDATE.
  - MEM_ADDRESS changes only after a word is accepted.
- UPDATE:
  - MEM_READ=0. Set valid[fill_index]=1 and tag_array[fill_index]=fill_tag; go to IDLE.
  - BUSYWAIT=1 throughout FETCH and UPDATE. The CPU sees a hit on the cycle after UPDATE.
- Miss latency, memory responding in L cycles per word: 4*L + 1 stall cycles + 1 hit cycle.
- Outputs during a stall: INSTRUCTION = data at the current ADDRESS's line (don't-care to the CPU). Outside hits, drive 32'h0 when READ=0.
- ADDRESS changing during FETCH/UPDATE: ignored. The fill completes with the latched address; the new address is evaluated in IDLE.
- READ deasserted mid-fill: the fill still completes.
- Reset values: state=IDLE, cnt=0, all valid=0, MEM_READ=0, MEM_ADDRESS=0, BUSYWAIT=0 (READ=0), INSTRUCTION=0.
- RESET mid-fill: abort immediately. The partial line stays invalid and MEM_READ drops on the next cycle.
- Data array is not cleared on reset.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0], both cleared by RESET.
  - HIT_COUNT increments on every IDLE cycle with hit=1.
  - MISS_COUNT increments on every IDLE->FETCH transition.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package icache_pkg:
  - FSM state typedef (IDLE/FETCH/UPDATE)
  - default ADDR_W, NUM_SETS, WORDS_PER_BLOCK constants
  - field-width localparam functions
- One sub-module, icache_data_array: valid/tag/data storage with a combinational read port and a synchronous word-write and tag/valid-update port.
- The FSM and counters stay in icache_controller.

Test Plan:
- Reset, then READ=1, ADDRESS=0x0, memory L=1 -> BUSYWAIT=1 for 5 cycles.
  - MEM_ADDRESS steps 0x0,0x4,0x8,0xC.
  - Next cycle INSTRUCTION=mem[0x0], BUSYWAIT=0.
- After that fill, ADDRESS=0x4, 0x8, 0xC on consecutive cycles -> BUSYWAIT=0 each cycle; INSTRUCTION matches memory words; MEM_READ stays 0.
- Conflict: fetch 0x000, then 0x080 (same index 0, tag 1), then 0x000 -> three misses, each with 4 MEM_READ words; the line is replaced each time.
- Memory with L=3 and MEM_BUSYWAIT toggling -> exactly 4 words written; MEM_ADDRESS held stable while MEM_BUSYWAIT=1; 13 stall cycles.
- RESET asserted on the 2nd word of the fill for 0x10, then re-fetch 0x10 -> full miss again (valid cleared); MEM_ADDRESS restarts at 0x10.
- With ICACHE_PERF_CNT_EN: 1 miss + 3 hits -> MISS_COUNT=1, HIT_COUNT=3; RESET -> both 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and sizing helpers for the direct-mapped instruction cache.
// Optional feature macro used by the cache: ICACHE_PERF_CNT_EN (hit/miss counters).
package icache_pkg;

  localparam int DEF_ADDR_W          = 10;
  localparam int DEF_NUM_SETS        = 8;
  localparam int DEF_WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Word-offset field width inside a line.
  function automatic int offset_w(input int words_per_block);
    return $clog2(words_per_block);
  endfunction

  // Index field width selecting a line.
  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  // Tag is whatever remains of the significant address above index, offset and byte bits.
  function automatic int tag_w(input int addr_w, input int num_sets, input int words_per_block);
    return addr_w - 2 - index_w(num_sets) - offset_w(words_per_block);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Valid/tag/data storage for the instruction cache: combinational read port,
// synchronous word write during fills and tag/valid update when a fill completes.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int NUM_SETS        = DEF_NUM_SETS,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int TAG_W           = 3
)(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [index_w(NUM_SETS)-1:0]         rd_index,
  input  logic [offset_w(WORDS_PER_BLOCK)-1:0] rd_word,
  output logic                                 rd_valid,
  output logic [TAG_W-1:0]                     rd_tag,
  output logic [31:0]                          rd_data,
  input  logic                                 wr_en,
  input  logic [index_w(NUM_SETS)-1:0]         wr_index,
  input  logic [offset_w(WORDS_PER_BLOCK)-1:0] wr_word,
  input  logic [31:0]                          wr_data,
  input  logic                                 upd_en,
  input  logic [index_w(NUM_SETS)-1:0]         upd_index,
  input  logic [TAG_W-1:0]                     upd_tag
);

  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tag_array  [NUM_SETS];
  logic [31:0]         data_array [NUM_SETS][WORDS_PER_BLOCK];

  // Valid bits: cleared by reset, set when a fill finishes.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      valid <= '0;
    end else if (upd_en) begin
      valid[upd_index] <= 1'b1;
    end
  end

  // Tag and data storage: written by the fill sequencer only.
  always_ff @(posedge clk) begin
    // NOTE: tag/data are deliberately left out of reset; the valid bit alone guards them.
    if (wr_en) begin
      data_array[wr_index][wr_word] <= wr_data;
    end
    if (upd_en) begin
      tag_array[upd_index] <= upd_tag;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_array[rd_index];
  assign rd_data  = data_array[rd_index][rd_word];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: combinational hits, stalling
// 4-word block fill from word-wide instruction memory on a miss.
// Optional macro ICACHE_PERF_CNT_EN adds saturating HIT_COUNT/MISS_COUNT outputs.
module icache_controller
  import icache_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int NUM_SETS        = DEF_NUM_SETS,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
)(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ADDRESS,
  input  logic        READ,
  output logic [31:0] INSTRUCTION,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic [31:0] MEM_ADDRESS,
  input  logic [31:0] MEM_READDATA,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0] HIT_COUNT,
  output logic [31:0] MISS_COUNT,
`endif
  input  logic        MEM_BUSYWAIT
);

  localparam int OFF_W = offset_w(WORDS_PER_BLOCK);
  localparam int IDX_W = index_w(NUM_SETS);
  localparam int TAG_W = tag_w(ADDR_W, NUM_SETS, WORDS_PER_BLOCK);

  state_t           state, next_state;
  logic [TAG_W-1:0] req_tag, fill_tag, line_tag;
  logic [IDX_W-1:0] req_index, fill_index;
  logic [OFF_W-1:0] req_word, cnt;
  logic [31:0]      line_word;
  logic             line_valid, hit, miss, word_accept, last_word, line_update;
  logic             unused_addr;

  assign req_word    = ADDRESS[2 +: OFF_W];
  assign req_index   = ADDRESS[2 + OFF_W +: IDX_W];
  assign req_tag     = ADDRESS[2 + OFF_W + IDX_W +: TAG_W];
  assign unused_addr = ^{ADDRESS[31:ADDR_W], ADDRESS[1:0]};

  assign hit         = READ & line_valid & (line_tag == req_tag);
  assign miss        = (state == IDLE) & READ & ~hit;
  assign word_accept = (state == FETCH) & ~MEM_BUSYWAIT;
  assign last_word   = (cnt == OFF_W'(WORDS_PER_BLOCK - 1));
  assign line_update = (state == UPDATE);

  icache_data_array #(
    .NUM_SETS        (NUM_SETS),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .TAG_W           (TAG_W)
  ) u_data_array (
    .clk       (CLK),
    .reset     (RESET),
    .rd_index  (req_index),
    .rd_word   (req_word),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_word),
    .wr_en     (word_accept),
    .wr_index  (fill_index),
    .wr_word   (cnt),
    .wr_data   (MEM_READDATA),
    .upd_en    (line_update),
    .upd_index (fill_index),
    .upd_tag   (fill_tag)
  );

  // State register; reset aborts any fill in progress.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Word counter: cleared on a new miss, advanced on each accepted memory word.
  always_ff @(posedge CLK) begin
    if (RESET)            cnt <= '0;
    else if (miss)        cnt <= '0;
    else if (word_accept) cnt <= cnt + OFF_W'(1);
  end

  // Fill target latched at the miss so later ADDRESS changes cannot redirect the fill.
  always_ff @(posedge CLK) begin
    if (miss) begin
      fill_tag   <= req_tag;
      fill_index <= req_index;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting every output first keeps combinational blocks latch-free.
    next_state = state;
    case (state)
      IDLE:    if (miss) next_state = FETCH;
      FETCH:   if (word_accept && last_word) next_state = UPDATE;
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode for the CPU and memory sides.
  always_comb begin
    BUSYWAIT    = 1'b0;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = '0;
    INSTRUCTION = READ ? line_word : 32'h0;
    case (state)
      IDLE:   BUSYWAIT = READ & ~hit;
      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = 32'({fill_tag, fill_index, cnt, 2'b00});
      end
      UPDATE: BUSYWAIT = 1'b1;
      default: BUSYWAIT = 1'b0;
    endcase
  end

`ifdef ICACHE_PERF_CNT_EN
  // Saturating hit/miss counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else begin
      if (state == IDLE && hit && HIT_COUNT != 32'hFFFF_FFFF)
        HIT_COUNT <= HIT_COUNT + 32'd1;
      if (miss && MISS_COUNT != 32'hFFFF_FFFF)
        MISS_COUNT <= MISS_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Directed self-checking bench for icache_controller with a latency-programmable
// word memory model. Build with ICACHE_PERF_CNT_EN to also exercise the counters.
module tb_icache_controller;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] ADDRESS = 32'h0;
  logic        READ = 1'b0;
  logic [31:0] INSTRUCTION;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] HIT_COUNT;
  logic [31:0] MISS_COUNT;
`endif

  int checks = 0;
  int errors = 0;

  icache_controller dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .READ         (READ),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
`ifdef ICACHE_PERF_CNT_EN
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT),
`endif
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory: word at byte address a holds 32'hC0DE_0000 | a (a word aligned, < 1024).
  // Each word takes mem_latency cycles: busy for mem_latency-1 cycles, then ready.
  int mem_latency = 1;
  int wait_cnt = 0;
  assign MEM_READDATA = MEM_READ ? (32'hC0DE_0000 | {22'd0, MEM_ADDRESS[9:2], 2'b00}) : 32'hDEAD_BEEF;
  assign MEM_BUSYWAIT = MEM_READ && (wait_cnt < mem_latency - 1);

  always @(posedge CLK) begin
    if (!MEM_READ || !MEM_BUSYWAIT) wait_cnt <= 0;
    else                            wait_cnt <= wait_cnt + 1;
  end

  // Log of accepted word addresses and a tally of address changes while memory is busy.
  logic [31:0] acc_log [256];
  int          acc_n = 0;
  logic [31:0] hold_addr = 32'h0;
  logic        hold_pend = 1'b0;
  int          unstable = 0;

  always @(negedge CLK) begin
    if (!RESET && MEM_READ && !MEM_BUSYWAIT && acc_n < 256) begin
      acc_log[acc_n] <= MEM_ADDRESS;
      acc_n <= acc_n + 1;
    end
    if (hold_pend && MEM_READ && MEM_ADDRESS !== hold_addr) unstable <= unstable + 1;
    hold_pend <= !RESET && MEM_READ && MEM_BUSYWAIT;
    hold_addr <= MEM_ADDRESS;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    READ = 1'b0;
    ADDRESS = 32'h0;
    tick();
    tick();
    RESET = 1'b0;
    #1;
  endtask

  // Issue a fetch; report whether it missed, the stall cycles after the miss cycle, and the data.
  task automatic do_fetch(input logic [31:0] addr, output logic missed, output int stall,
                          output logic [31:0] instr);
    ADDRESS = addr;
    READ = 1'b1;
    #1;
    missed = BUSYWAIT;
    stall = 0;
    if (BUSYWAIT === 1'b1) begin
      tick();
      while (BUSYWAIT === 1'b1 && stall < 500) begin
        stall++;
        tick();
      end
      checks++;
      if (stall >= 500) begin
        errors++;
        $display("FAIL fetch_timeout addr=%h stall=%0d limit=500", addr, stall);
      end
    end
    instr = INSTRUCTION;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (BUSYWAIT !== 1'b0)     begin errors++; $display("FAIL reset_busywait got=%b exp=0", BUSYWAIT); end
    checks++; if (MEM_READ !== 1'b0)     begin errors++; $display("FAIL reset_mem_read got=%b exp=0", MEM_READ); end
    checks++; if (MEM_ADDRESS !== 32'h0) begin errors++; $display("FAIL reset_mem_address got=%h exp=0", MEM_ADDRESS); end
    checks++; if (INSTRUCTION !== 32'h0) begin errors++; $display("FAIL reset_instruction got=%h exp=0", INSTRUCTION); end
  endtask

  task automatic test_first_miss();
    logic [31:0] exp_addr [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic        missed;
    int          stall;
    logic [31:0] instr;
    int          base = acc_n;
    do_fetch(32'h0, missed, stall, instr);
    checks++; if (missed !== 1'b1)          begin errors++; $display("FAIL miss0_detect got=%b exp=1", missed); end
    checks++; if (stall != 5)               begin errors++; $display("FAIL miss0_stall got=%0d exp=5", stall); end
    checks++; if (instr !== 32'hC0DE_0000)  begin errors++; $display("FAIL miss0_instr got=%h exp=C0DE0000", instr); end
    checks++; if (BUSYWAIT !== 1'b0)        begin errors++; $display("FAIL miss0_hit_busywait got=%b exp=0", BUSYWAIT); end
    checks++; if (acc_n - base != 4)        begin errors++; $display("FAIL miss0_words got=%0d exp=4", acc_n - base); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (acc_log[base + i] !== exp_addr[i]) begin
        errors++; $display("FAIL miss0_mem_address[%0d] got=%h exp=%h", i, acc_log[base + i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_hits();
    logic [31:0] addr_tab [3] = '{32'h4, 32'h8, 32'hC};
    logic [31:0] data_tab [3] = '{32'hC0DE_0004, 32'hC0DE_0008, 32'hC0DE_000C};
    int          base = acc_n;
    for (int i = 0; i < 3; i++) begin
      tick();
      ADDRESS = addr_tab[i];
      #1;
      checks++; if (BUSYWAIT !== 1'b0)         begin errors++; $display("FAIL hit_busywait[%0d] got=%b exp=0", i, BUSYWAIT); end
      checks++; if (INSTRUCTION !== data_tab[i]) begin errors++; $display("FAIL hit_instr[%0d] got=%h exp=%h", i, INSTRUCTION, data_tab[i]); end
      checks++; if (MEM_READ !== 1'b0)         begin errors++; $display("FAIL hit_mem_read[%0d] got=%b exp=0", i, MEM_READ); end
    end
    tick();
    checks++; if (acc_n != base) begin errors++; $display("FAIL hit_no_mem_words got=%0d exp=0", acc_n - base); end
  endtask

  task automatic test_conflict();
    logic [31:0] addr_tab [3] = '{32'h000, 32'h080, 32'h000};
    logic [31:0] data_tab [3] = '{32'hC0DE_0000, 32'hC0DE_0080, 32'hC0DE_0000};
    logic        missed;
    int          stall;
    logic [31:0] instr;
    int          base;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      base = acc_n;
      do_fetch(addr_tab[i], missed, stall, instr);
      checks++; if (missed !== 1'b1)      begin errors++; $display("FAIL conflict_miss[%0d] got=%b exp=1", i, missed); end
      checks++; if (instr !== data_tab[i]) begin errors++; $display("FAIL conflict_instr[%0d] got=%h exp=%h", i, instr, data_tab[i]); end
      checks++; if (acc_n - base != 4)    begin errors++; $display("FAIL conflict_words[%0d] got=%0d exp=4", i, acc_n - base); end
      checks++; if (acc_log[base] !== addr_tab[i]) begin errors++; $display("FAIL conflict_first_addr[%0d] got=%h exp=%h", i, acc_log[base], addr_tab[i]); end
      checks++; if (acc_log[base + 3] !== (addr_tab[i] | 32'hC)) begin
        errors++; $display("FAIL conflict_last_addr[%0d] got=%h exp=%h", i, acc_log[base + 3], addr_tab[i] | 32'hC);
      end
    end
  endtask

  task automatic test_slow_memory();
    logic [31:0] exp_addr [4] = '{32'h40, 32'h44, 32'h48, 32'h4C};
    logic        missed;
    int          stall;
    logic [31:0] instr;
    int          base;
    mem_latency = 3;
    tick();
    base = acc_n;
    do_fetch(32'h40, missed, stall, instr);
    checks++; if (missed !== 1'b1)         begin errors++; $display("FAIL slow_miss got=%b exp=1", missed); end
    checks++; if (stall != 13)             begin errors++; $display("FAIL slow_stall got=%0d exp=13", stall); end
    checks++; if (acc_n - base != 4)       begin errors++; $display("FAIL slow_words got=%0d exp=4", acc_n - base); end
    checks++; if (unstable != 0)           begin errors++; $display("FAIL slow_addr_stable got=%0d changes exp=0", unstable); end
    checks++; if (instr !== 32'hC0DE_0040) begin errors++; $display("FAIL slow_instr got=%h exp=C0DE0040", instr); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (acc_log[base + i] !== exp_addr[i]) begin
        errors++; $display("FAIL slow_mem_address[%0d] got=%h exp=%h", i, acc_log[base + i], exp_addr[i]);
      end
    end
    mem_latency = 1;
  endtask

  task automatic test_reset_mid_fill();
    logic        missed;
    int          stall;
    logic [31:0] instr;
    int          base;
    tick();
    ADDRESS = 32'h10;
    READ = 1'b1;
    tick();
    tick();
    checks++; if (MEM_ADDRESS !== 32'h14) begin errors++; $display("FAIL abort_second_word got=%h exp=00000014", MEM_ADDRESS); end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    checks++; if (MEM_READ !== 1'b0)     begin errors++; $display("FAIL abort_mem_read got=%b exp=0", MEM_READ); end
    checks++; if (MEM_ADDRESS !== 32'h0) begin errors++; $display("FAIL abort_mem_address got=%h exp=0", MEM_ADDRESS); end
    base = acc_n;
    do_fetch(32'h10, missed, stall, instr);
    checks++; if (missed !== 1'b1)         begin errors++; $display("FAIL refetch_miss got=%b exp=1", missed); end
    checks++; if (stall != 5)              begin errors++; $display("FAIL refetch_stall got=%0d exp=5", stall); end
    checks++; if (acc_log[base] !== 32'h10) begin errors++; $display("FAIL refetch_first_addr got=%h exp=00000010", acc_log[base]); end
    checks++; if (instr !== 32'hC0DE_0010) begin errors++; $display("FAIL refetch_instr got=%h exp=C0DE0010", instr); end
    tick();
    do_fetch(32'h40, missed, stall, instr);
    checks++; if (missed !== 1'b1)         begin errors++; $display("FAIL reset_cleared_valid got=%b exp=1", missed); end
    checks++; if (instr !== 32'hC0DE_0040) begin errors++; $display("FAIL reset_cleared_instr got=%h exp=C0DE0040", instr); end
  endtask

  task automatic test_read_drop_mid_fill();
    int base;
    tick();
    base = acc_n;
    ADDRESS = 32'h20;
    READ = 1'b1;
    tick();
    ADDRESS = 32'h3F0;
    READ = 1'b0;
    #1;
    checks++; if (BUSYWAIT !== 1'b1)      begin errors++; $display("FAIL drop_busywait got=%b exp=1", BUSYWAIT); end
    checks++; if (MEM_ADDRESS !== 32'h20) begin errors++; $display("FAIL drop_mem_address got=%h exp=00000020", MEM_ADDRESS); end
    repeat (5) tick();
    checks++; if (BUSYWAIT !== 1'b0)      begin errors++; $display("FAIL drop_done_busywait got=%b exp=0", BUSYWAIT); end
    checks++; if (INSTRUCTION !== 32'h0)  begin errors++; $display("FAIL drop_idle_instr got=%h exp=0", INSTRUCTION); end
    checks++; if (acc_n - base != 4)      begin errors++; $display("FAIL drop_words got=%0d exp=4", acc_n - base); end
    checks++; if (acc_log[base + 3] !== 32'h2C) begin errors++; $display("FAIL drop_last_addr got=%h exp=0000002C", acc_log[base + 3]); end
    ADDRESS = 32'h24;
    READ = 1'b1;
    #1;
    checks++; if (BUSYWAIT !== 1'b0)         begin errors++; $display("FAIL drop_hit_busywait got=%b exp=0", BUSYWAIT); end
    checks++; if (INSTRUCTION !== 32'hC0DE_0024) begin errors++; $display("FAIL drop_hit_instr got=%h exp=C0DE0024", INSTRUCTION); end
    tick();
    ADDRESS = 32'h3F0;
    #1;
    checks++; if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL new_addr_miss got=%b exp=1", BUSYWAIT); end
    READ = 1'b0;
    tick();
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic test_perf_counters();
    logic        missed;
    int          stall;
    logic [31:0] instr;
    do_reset();
    do_fetch(32'h0, missed, stall, instr);
    tick();
    ADDRESS = 32'h4;
    tick();
    ADDRESS = 32'h8;
    tick();
    READ = 1'b0;
    #1;
    checks++; if (MISS_COUNT !== 32'd1) begin errors++; $display("FAIL perf_miss got=%0d exp=1", MISS_COUNT); end
    checks++; if (HIT_COUNT !== 32'd3)  begin errors++; $display("FAIL perf_hit got=%0d exp=3", HIT_COUNT); end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    checks++; if (MISS_COUNT !== 32'd0) begin errors++; $display("FAIL perf_miss_reset got=%0d exp=0", MISS_COUNT); end
    checks++; if (HIT_COUNT !== 32'd0)  begin errors++; $display("FAIL perf_hit_reset got=%0d exp=0", HIT_COUNT); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_miss();
    test_hits();
    test_conflict();
    test_slow_memory();
    test_reset_mid_fill();
    test_read_drop_mid_fill();
`ifdef ICACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
